// File: rtl/buf_alloc_pkg.sv
// Shared constants, FSM state encoding and helpers for the buffer allocation controller.
package buf_alloc_pkg;

    localparam int NUM_BUF   = 4;
    localparam int BUF_IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        EVICT  = 2'd2,
        VICTIM = 2'd3
    } state_t;

    // Lowest-index entry whose valid bit is clear; returns 0 when the table is full.
    function automatic logic [BUF_IDX_W-1:0] lowest_free(input logic [NUM_BUF-1:0] valid);
        logic [BUF_IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_BUF - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                idx = BUF_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority starts just after the last granted index.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr;
    logic          found;
    int            idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/buf_alloc_ctrl.sv
// Buffer allocation controller: arbitrates requesters, maps tags onto a 4-entry buffer pool
// and sequences the LFU replacement engine. Optional flush port via BUF_ALLOC_FLUSH_EN.
module buf_alloc_ctrl
    import buf_alloc_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef BUF_ALLOC_FLUSH_EN
    input  logic                     flush,
`endif
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic [NUM_REQ-1:0]       ack,
    output logic [BUF_IDX_W-1:0]     ack_buf,
    output logic                     ack_hit,
    output logic                     lfu_ref_vld,
    output logic [BUF_IDX_W-1:0]     lfu_ref_buf,
    output logic                     lfu_new_req,
    input  logic [BUF_IDX_W-1:0]     lfu_victim,
    output logic                     busy
);

    state_t                 state;
    logic [NUM_BUF-1:0]     valid;
    logic [TAG_W-1:0]       tag_tbl [NUM_BUF];
    logic [NUM_REQ-1:0]     cur_grant;
    logic [TAG_W-1:0]       cur_tag;

    logic [NUM_REQ-1:0]     grant;
    logic [$clog2(NUM_REQ)-1:0] grant_idx;
    logic                   arb_go;
    logic [TAG_W-1:0]       sel_tag;
    logic                   hit;
    logic [BUF_IDX_W-1:0]   hit_idx;
    logic [BUF_IDX_W-1:0]   free_idx;

    // The acked requester still holds req during its ack cycle, so IDLE skips that cycle.
    assign arb_go = (state == IDLE) && (ack == '0) && (|req);

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .advance   (arb_go),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_tag = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ($clog2(NUM_REQ))'(i)) begin
                sel_tag = req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_BUF; i++) begin
            if (valid[i] && (tag_tbl[i] == cur_tag)) begin
                hit     = 1'b1;
                hit_idx = BUF_IDX_W'(i);
            end
        end
    end

    assign free_idx = lowest_free(valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            valid       <= '0;
            cur_grant   <= '0;
            cur_tag     <= '0;
            ack         <= '0;
            ack_buf     <= '0;
            ack_hit     <= 1'b0;
            lfu_ref_vld <= 1'b0;
            lfu_ref_buf <= '0;
            lfu_new_req <= 1'b0;
            busy        <= 1'b0;
            for (int i = 0; i < NUM_BUF; i++) begin
                tag_tbl[i] <= '0;
            end
        end else begin
            ack         <= '0;
            lfu_ref_vld <= 1'b0;
            lfu_new_req <= 1'b0;
`ifdef BUF_ALLOC_FLUSH_EN
            // A same-edge tag write below overrides this, keeping just the new entry.
            if (flush) begin
                valid <= '0;
            end
`endif
            case (state)
                IDLE: begin
                    if (arb_go) begin
                        cur_grant <= grant;
                        cur_tag   <= sel_tag;
                        state     <= LOOKUP;
                        busy      <= 1'b1;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        ack         <= cur_grant;
                        ack_buf     <= hit_idx;
                        ack_hit     <= 1'b1;
                        lfu_ref_vld <= 1'b1;
                        lfu_ref_buf <= hit_idx;
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end else if (!(&valid)) begin
                        valid[free_idx]   <= 1'b1;
                        tag_tbl[free_idx] <= cur_tag;
                        ack               <= cur_grant;
                        ack_buf           <= free_idx;
                        ack_hit           <= 1'b0;
                        lfu_ref_vld       <= 1'b1;
                        lfu_ref_buf       <= free_idx;
                        state             <= IDLE;
                        busy              <= 1'b0;
                    end else begin
                        lfu_new_req <= 1'b1;
                        state       <= EVICT;
                    end
                end
                EVICT: begin
                    state <= VICTIM;
                end
                VICTIM: begin
                    valid[lfu_victim]   <= 1'b1;
                    tag_tbl[lfu_victim] <= cur_tag;
                    ack                 <= cur_grant;
                    ack_buf             <= lfu_victim;
                    ack_hit             <= 1'b0;
                    lfu_ref_vld         <= 1'b1;
                    lfu_ref_buf         <= lfu_victim;
                    state               <= IDLE;
                    busy                <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buf_alloc_ctrl.sv
// Directed self-checking bench for buf_alloc_ctrl; flush scenarios run when BUF_ALLOC_FLUSH_EN is defined.
module tb_buf_alloc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_tag;
    logic [3:0]  ack;
    logic [1:0]  ack_buf;
    logic        ack_hit;
    logic        lfu_ref_vld;
    logic [1:0]  lfu_ref_buf;
    logic        lfu_new_req;
    logic [1:0]  lfu_victim;
    logic        busy;
`ifdef BUF_ALLOC_FLUSH_EN
    logic        flush = 1'b0;
    logic        flushAtLookup = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    buf_alloc_ctrl #(.NUM_REQ(4), .TAG_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef BUF_ALLOC_FLUSH_EN
        .flush       (flush),
`endif
        .req         (req),
        .req_tag     (req_tag),
        .ack         (ack),
        .ack_buf     (ack_buf),
        .ack_hit     (ack_hit),
        .lfu_ref_vld (lfu_ref_vld),
        .lfu_ref_buf (lfu_ref_buf),
        .lfu_new_req (lfu_new_req),
        .lfu_victim  (lfu_victim),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        req   = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One requester, started with the FSM idle; req stays high through its ack cycle.
    task automatic applyStimulus(input int idx, input logic [7:0] tag, input logic [1:0] expBuf,
                                 input logic expHit, input int expLat, input string name);
        int cyc;
        int newReqs;
        cyc     = 0;
        newReqs = 0;
        req[idx]            = 1'b1;
        req_tag[idx*8 +: 8] = tag;
        do begin
            tick();
            cyc++;
            if (lfu_new_req) newReqs++;
`ifdef BUF_ALLOC_FLUSH_EN
            flush = flushAtLookup && (cyc == 1);
`endif
        end while (ack == '0 && cyc < 12);
`ifdef BUF_ALLOC_FLUSH_EN
        flush = 1'b0;
`endif
        checkOutput({name, "_lat"},     cyc, expLat);
        checkOutput({name, "_ack"},     ack, 32'(4'b1 << idx));
        checkOutput({name, "_buf"},     ack_buf, expBuf);
        checkOutput({name, "_hit"},     ack_hit, expHit);
        checkOutput({name, "_refvld"},  lfu_ref_vld, 1);
        checkOutput({name, "_refbuf"},  lfu_ref_buf, expBuf);
        checkOutput({name, "_newreq"},  newReqs, (expLat == 4) ? 1 : 0);
        tick();
        checkOutput({name, "_idle"},    busy, 0);
        req[idx] = 1'b0;
    endtask

    // All four requesters held together; acks expected in rotation, 3 cycles apart.
    task automatic runConcurrent(input int numAcks, input logic expHit, input logic dropAfterAck,
                                 input string name);
        int cyc;
        int k;
        for (int n = 0; n < numAcks; n++) begin
            k   = n % 4;
            cyc = 0;
            do begin
                tick();
                cyc++;
            end while (ack == '0 && cyc < 12);
            checkOutput($sformatf("%s%0d_gap", name, n), cyc, (n == 0) ? 2 : 3);
            checkOutput($sformatf("%s%0d_ack", name, n), ack, 32'(4'b1 << k));
            checkOutput($sformatf("%s%0d_buf", name, n), ack_buf, k);
            checkOutput($sformatf("%s%0d_hit", name, n), ack_hit, expHit);
            if (dropAfterAck) req[k] = 1'b0;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req        = '0;
        req_tag    = '0;
        lfu_victim = 2'd0;
        tick();
        tick();
        checkOutput("rst_ack",     ack, 0);
        checkOutput("rst_ackbuf",  ack_buf, 0);
        checkOutput("rst_ackhit",  ack_hit, 0);
        checkOutput("rst_refvld",  lfu_ref_vld, 0);
        checkOutput("rst_refbuf",  lfu_ref_buf, 0);
        checkOutput("rst_newreq",  lfu_new_req, 0);
        checkOutput("rst_busy",    busy, 0);
        rst_n = 1'b1;
        tick();

        $display("[TB] first request");
        applyStimulus(0, 8'h10, 2'd0, 1'b0, 2, "first");

        $display("[TB] fill from four requesters");
        doReset();
        req_tag = {8'h13, 8'h12, 8'h11, 8'h10};
        req     = 4'hF;
        runConcurrent(4, 1'b0, 1'b1, "fill");
        tick();
        applyStimulus(1, 8'h12, 2'd2, 1'b1, 2, "hit12");

        $display("[TB] eviction");
        lfu_victim = 2'd3;
        applyStimulus(2, 8'h55, 2'd3, 1'b0, 4, "evict55");
        lfu_victim = 2'd0;
        applyStimulus(3, 8'h13, 2'd0, 1'b0, 4, "evict13");
        applyStimulus(3, 8'h55, 2'd3, 1'b1, 2, "hit55");

        $display("[TB] rotation");
        req_tag = {8'h55, 8'h12, 8'h11, 8'h13};
        req     = 4'hF;
        runConcurrent(5, 1'b1, 1'b0, "rot");
        req = '0;
        tick();

        $display("[TB] reset during VICTIM");
        req[1]          = 1'b1;
        req_tag[15:8]   = 8'h77;
        tick();
        tick();
        tick();
        checkOutput("victim_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_busy", busy, 0);
        checkOutput("async_ack",  ack, 0);
        tick();
        checkOutput("rst_hold_ack", ack, 0);
        req   = '0;
        rst_n = 1'b1;
        tick();
        applyStimulus(0, 8'h10, 2'd0, 1'b0, 2, "postrst");

`ifdef BUF_ALLOC_FLUSH_EN
        $display("[TB] flush");
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i, 8'h20 + 8'(i), 2'(i), 1'b0, 2, $sformatf("pre%0d", i));
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i, 8'h20 + 8'(i), 2'(i), 1'b0, 2, $sformatf("post%0d", i));
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        applyStimulus(0, 8'h30, 2'd0, 1'b0, 2, "fw30");
        flushAtLookup = 1'b1;
        applyStimulus(1, 8'h31, 2'd1, 1'b0, 2, "fw31");
        flushAtLookup = 1'b0;
        applyStimulus(0, 8'h30, 2'd0, 1'b0, 2, "fw30again");
        applyStimulus(1, 8'h31, 2'd1, 1'b1, 2, "fw31hit");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/buf_alloc_ctrl.md
# buf_alloc_ctrl

Buffer allocation controller that shares the 4-entry buffer pool among several requesters and sequences the `lfu_finder` replacement engine. Each requester presents a tag. The block round-robin arbitrates, looks the tag up in a 4-entry tag table, and returns the buffer number. On a hit it reuses the buffer. On a miss it takes a free buffer, or asks `lfu_finder` for the least-frequently-used victim. Every granted access is reported to `lfu_finder` so its access counters stay current.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- TAG_W, 8, tag width in bits
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester request level; held until that requester's ack
- req_tag  in  NUM_REQ*TAG_W  tag of requester i at bits [i*TAG_W +: TAG_W]; stable while req[i]=1
- ack  out  NUM_REQ  one-hot, one-cycle grant-complete pulse
- ack_buf  out  2  buffer number for the acked request; valid only while ack≠0
- ack_hit  out  1  1 = tag was already resident; valid only while ack≠0
- lfu_ref_vld  out  1  one-cycle pulse: an access to lfu_ref_buf occurred
- lfu_ref_buf  out  2  buffer referenced (drives ref_buf_numbr)
- lfu_new_req  out  1  one-cycle pulse requesting a victim (drives new_buf_req)
- lfu_victim  in  2  victim buffer number (from buf_num_replc)
- busy  out  1  FSM not in IDLE

## Operation
- Tag table: 4 entries, each holding valid + TAG_W tag. All valid bits clear on reset.
- FSM states and transitions:
  - IDLE: if any req bit is set, the rr_arbiter picks a winner. The winner index and tag are latched, and the FSM moves to LOOKUP.
  - LOOKUP: parallel compare against the valid entries.
    - Hit: ack, ack_hit=1, lfu_ref pulse, go to IDLE.
    - Miss with a free entry: write the lowest-index free entry, ack with ack_hit=0, lfu_ref pulse, go to IDLE.
    - Miss with all entries valid: go to EVICT.
  - EVICT: pulse lfu_new_req, go to VICTIM.
  - VICTIM: sample lfu_victim, overwrite that entry's tag, ack with ack_hit=0 and ack_buf=victim, lfu_ref pulse on the victim, go to IDLE.
- Round-robin priority starts after the last granted index. The priority pointer resets to index 0.
- Duplicate tags are impossible: a miss writes only after the lookup has failed.
- A requester dropping req before its ack is illegal. The block still completes and acks it.
- Reset mid-operation: FSM returns to IDLE, the table clears, and no ack is issued.

## Timing
- Reset values: ack=0, ack_buf=0, ack_hit=0, lfu_ref_vld=0, lfu_ref_buf=0, lfu_new_req=0, busy=0.
- All outputs are registered.
- Latency is counted from the cycle req is sampled in IDLE:
  - hit: ack 2 cycles later
  - free-entry miss: ack 2 cycles later
  - eviction: ack 4 cycles later
- lfu_ref_vld/lfu_ref_buf are asserted in the same cycle as ack.
- lfu_victim is sampled exactly 1 cycle after lfu_new_req. lfu_finder must hold buf_num_replc valid by then.
- Maximum throughput is one request per 3 cycles, since the FSM returns to IDLE between requests.
- A requester's req bit may be re-asserted the cycle after its ack.

## Configuration
- BUF_ALLOC_FLUSH_EN defined:
  - Adds input port `flush` (1 bit).
  - flush=1 clears all valid bits at the clock edge.
  - If flush coincides with a tag write (LOOKUP free-miss or VICTIM), the written entry stays valid and all others clear.
  - An in-flight request still completes.
- BUF_ALLOC_FLUSH_EN undefined: no flush port; valid bits clear only on reset.

## Structure
- Package buf_alloc_pkg holds:
  - NUM_BUF=4
  - BUF_IDX_W=2
  - the state enum (IDLE, LOOKUP, EVICT, VICTIM)
- Sub-module rr_arbiter (parameter N) provides round-robin one-hot grant with the pointer update gated by an `advance` input.

## Test plan
- Reset, then req[0] with tag 0x10 → 2 cycles later ack=0001, ack_buf=0, ack_hit=0, lfu_ref_buf=0.
- Fill tags 0x10, 0x11, 0x12, 0x13 from req[0..3] at once → acks in order 0,1,2,3, buffers 0,1,2,3; then req[1] with tag 0x12 → ack_hit=1, ack_buf=2.
- Table full, req[2] with tag 0x55, model drives lfu_victim=3 → lfu_new_req pulses once, ack 4 cycles after sampling with ack_buf=3, ack_hit=0; a later lookup of tag 0x13 misses.
- All req bits held continuously with distinct resident tags → grants rotate 0,1,2,3,0 with no starvation.
- rst_n low during VICTIM → no ack, busy=0 asynchronously, the next tag 0x10 misses into buffer 0.
- With BUF_ALLOC_FLUSH_EN, flush in the cycle after a full table → all four tags miss; flush coincident with a write → only that entry hits.
